mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM-stage load/store unit placed directly downstream of the EX-stage adder/ALU.
- Takes the EX result as an effective address (or as a plain result for non-memory ops) and runs one single-beat req/ack transaction on the data-RAM port for loads and stores.
- Stalls the pipeline while a transaction is outstanding.
- Formats load data (byte/half extraction, sign/zero extension) and presents a registered writeback bundle to the WB stage.

Parameters:
- DATA_WIDTH, 32, datapath and bus data width (only 32 is supported).
- ADDR_WIDTH, 32, address width.
- TIMEOUT, 16, maximum cycles in BUS before a bus error; legal range 2..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX presents a valid instruction this cycle
- ex_mem_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
- ex_result  in  32  adder/ALU result; the effective address when ex_mem_op != NONE
- ex_store_data  in  32  rt value for stores
- ex_wb_reg  in  5  destination register
- ex_wb_en  in  1  instruction writes a register
- flush  in  1  kill the current and pending instruction
- mem_stall_req  out  1  hold EX/upstream
- ram_req  out  1  bus request
- ram_we  out  1  1 = write
- ram_addr  out  32  word address, bits [1:0] = 0
- ram_be  out  4  byte enables, little-endian (be[0] = bits 7:0)
- ram_wdata  out  32  store data replicated into lanes
- ram_ack  in  1  transaction complete; ram_rdata valid in the same cycle
- ram_rdata  in  32  read data
- wb_valid  out  1  writeback bundle valid (1-cycle pulse per instruction)
- wb_en  out  1  register write enable
- wb_reg  out  5  destination register
- wb_data  out  32  result or formatted load data
- addr_exc  out  1  misaligned-access pulse
- bus_err  out  1  timeout pulse
- exc_addr  out  32  faulting address, valid with addr_exc or bus_err

Behaviour:
- Reset: all outputs are 0, state is IDLE, timeout counter is 0. Reset during BUS drops ram_req the next cycle with no completion.
- States: IDLE and BUS.
- mem_stall_req = (state == BUS). It is high on the ack cycle too; upstream advances on the cycle after the ack.
- IDLE, ex_valid = 1, flush = 0:
  - NONE: next cycle wb_valid = 1, wb_data = ex_result, wb_en = ex_wb_en, wb_reg = ex_wb_reg.
  - Misaligned access (half with addr[0] = 1, word with addr[1:0] != 0): no bus cycle. Next cycle addr_exc = 1, exc_addr = addr, wb_valid = 1, wb_en = 0.
  - Aligned access: latch op, addr, data and reg; go to BUS. ram_req is high from the next cycle.
- BUS:
  - ram_req, ram_we, ram_addr, ram_be and ram_wdata are registered and held stable until ram_ack.
  - Byte enables: SB gives be = 1 << addr[1:0]; SH gives be = addr[1] ? 1100 : 0011; SW gives 1111; loads drive 1111.
  - Write data: SB replicates byte[7:0] into all four lanes; SH replicates the halfword into both halves.
  - On ram_ack: ram_req drops the next cycle and state returns to IDLE. wb_valid is asserted the next cycle.
  - Loads: wb_en = latched wb_en and wb_data is the selected lane, sign-extended (LB/LH) or zero-extended (LBU/LHU). LW passes the word through.
  - Stores: wb_en = 0.
- Timeout: the counter increments each BUS cycle without ack. When it reaches TIMEOUT-1 with no ack, next cycle ram_req = 0, bus_err = 1, exc_addr = addr, wb_valid = 1, wb_en = 0, and state returns to IDLE. An ack in that same cycle wins over the timeout.
- flush:
  - In IDLE: the incoming instruction is discarded and no outputs are asserted next cycle.
  - In BUS: the transaction still runs to ack or timeout (the bus is never abandoned), but wb_valid, addr_exc and bus_err are suppressed for it.
- ex_valid is ignored while in BUS.
- wb_valid, addr_exc and bus_err are single-cycle pulses; wb_data and wb_reg hold their values otherwise.

Test Plan:
- NONE op, ex_result = 0x1234_5678, wb_reg = 3 -> 1 cycle later wb_valid = 1, wb_data = 0x12345678, wb_en = 1, no ram_req, stall = 0.
- LB addr 0x103, ram_rdata = 0x80FF_0011, ack after 3 cycles -> ram_addr = 0x100, be = 1111, stall high 4 cycles, wb_data = 0xFFFF_FF80. LBU with the same inputs -> 0x0000_0080.
- SH addr 0x202, data 0xABCD_1234 -> ram_we = 1, be = 1100, wdata = 0x1234_1234, wb_valid = 1 with wb_en = 0.
- LW addr 0x206 -> no ram_req, addr_exc pulse, exc_addr = 0x206, wb_en = 0.
- SW with no ack, TIMEOUT = 16 -> ram_req held for 16 cycles then dropped, bus_err pulse, exc_addr correct; the next NONE op completes normally.
- LW, flush asserted in the 2nd BUS cycle, ack in the 5th -> stall held through the ack, no wb_valid. rst asserted during BUS -> ram_req = 0 the next cycle, all outputs are 0.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-RAM port bundle between the MEM stage (master) and the data RAM (slave).
interface mem_access_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  ram_req;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [3:0]            ram_be;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_ack;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport master (
        output ram_req, ram_we, ram_addr, ram_be, ram_wdata,
        input  ram_ack, ram_rdata
    );

    modport slave (
        input  ram_req, ram_we, ram_addr, ram_be, ram_wdata,
        output ram_ack, ram_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: one single-beat req/ack RAM transaction per
// aligned load/store, load-data formatting and a registered writeback bundle.
//
// state | meaning
// IDLE  | accepting EX instructions; NONE ops and misaligned accesses retire here
// BUS   | transaction outstanding; pipeline stalled until ack or timeout
module mem_access_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [3:0]            ex_mem_op,
    input  logic [DATA_WIDTH-1:0] ex_result,
    input  logic [DATA_WIDTH-1:0] ex_store_data,
    input  logic [4:0]            ex_wb_reg,
    input  logic                  ex_wb_en,
    input  logic                  flush,
    output logic                  mem_stall_req,
    mem_access_stage_if.master    ram,
    output logic                  wb_valid,
    output logic                  wb_en,
    output logic [4:0]            wb_reg,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  addr_exc,
    output logic                  bus_err,
    output logic [ADDR_WIDTH-1:0] exc_addr
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic {S_IDLE, S_BUS} state_t;

    state_t                state;
    logic [7:0]            cnt;
    logic [3:0]            lat_op;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [4:0]            lat_reg;
    logic                  lat_wb_en;
    logic                  killed;

    logic                  req_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            be_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [ADDR_WIDTH-1:0] ex_addr;
    logic                  op_mem;
    logic                  op_store;
    logic                  misaligned;
    logic [3:0]            be_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic                  lat_load;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] load_data;

    assign ram.ram_req   = req_q;
    assign ram.ram_we    = we_q;
    assign ram.ram_addr  = addr_q;
    assign ram.ram_be    = be_q;
    assign ram.ram_wdata = wdata_q;
    assign mem_stall_req = (state == S_BUS);
    assign ex_addr       = ex_result[ADDR_WIDTH-1:0];

    // Decode the EX op: alignment, byte enables and lane-replicated store data.
    always_comb begin
        op_mem     = (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_SW);
        op_store   = (ex_mem_op >= OP_SB) && (ex_mem_op <= OP_SW);
        misaligned = 1'b0;
        be_next    = 4'b1111;
        wdata_next = ex_store_data;
        case (ex_mem_op)
            OP_LH, OP_LHU: misaligned = ex_addr[0];
            OP_LW, OP_SW:  misaligned = (ex_addr[1:0] != 2'b00);
            OP_SH: begin
                misaligned = ex_addr[0];
                be_next    = ex_addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{ex_store_data[15:0]}};
            end
            OP_SB: begin
                be_next    = 4'b0001 << ex_addr[1:0];
                wdata_next = {4{ex_store_data[7:0]}};
            end
            default: ;
        endcase
    end

    // Select and extend the addressed lane of the returning read data.
    always_comb begin
        lat_load = (lat_op >= OP_LB) && (lat_op <= OP_LW);
        case (lat_addr[1:0])
            2'd0:    rd_byte = ram.ram_rdata[7:0];
            2'd1:    rd_byte = ram.ram_rdata[15:8];
            2'd2:    rd_byte = ram.ram_rdata[23:16];
            default: rd_byte = ram.ram_rdata[31:24];
        endcase
        rd_half = lat_addr[1] ? ram.ram_rdata[31:16] : ram.ram_rdata[15:0];
        case (lat_op)
            OP_LB:   load_data = {{(DATA_WIDTH-8){rd_byte[7]}}, rd_byte};
            OP_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, rd_byte};
            OP_LH:   load_data = {{(DATA_WIDTH-16){rd_half[15]}}, rd_half};
            OP_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, rd_half};
            default: load_data = ram.ram_rdata;
        endcase
    end

    // Sequencer: accept from EX, run the bus beat, retire to WB with pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_op    <= '0;
            lat_addr  <= '0;
            lat_reg   <= '0;
            lat_wb_en <= 1'b0;
            killed    <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            wb_valid  <= 1'b0;
            wb_en     <= 1'b0;
            wb_reg    <= '0;
            wb_data   <= '0;
            addr_exc  <= 1'b0;
            bus_err   <= 1'b0;
            exc_addr  <= '0;
        end else begin
            wb_valid <= 1'b0;
            addr_exc <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ex_valid && !flush) begin
                        if (!op_mem) begin
                            wb_valid <= 1'b1;
                            wb_en    <= ex_wb_en;
                            wb_reg   <= ex_wb_reg;
                            wb_data  <= ex_result;
                        end else if (misaligned) begin
                            wb_valid <= 1'b1;
                            wb_en    <= 1'b0;
                            wb_reg   <= ex_wb_reg;
                            addr_exc <= 1'b1;
                            exc_addr <= ex_addr;
                        end else begin
                            state     <= S_BUS;
                            cnt       <= '0;
                            killed    <= 1'b0;
                            lat_op    <= ex_mem_op;
                            lat_addr  <= ex_addr;
                            lat_reg   <= ex_wb_reg;
                            lat_wb_en <= ex_wb_en;
                            req_q     <= 1'b1;
                            we_q      <= op_store;
                            addr_q    <= {ex_addr[ADDR_WIDTH-1:2], 2'b00};
                            be_q      <= be_next;
                            wdata_q   <= wdata_next;
                        end
                    end
                end
                S_BUS: begin
                    if (flush) killed <= 1'b1;
                    // Ack beats the timeout when both land in the same cycle.
                    if (ram.ram_ack) begin
                        state <= S_IDLE;
                        req_q <= 1'b0;
                        if (!(killed || flush)) begin
                            wb_valid <= 1'b1;
                            wb_reg   <= lat_reg;
                            wb_en    <= lat_load ? lat_wb_en : 1'b0;
                            if (lat_load) wb_data <= load_data;
                        end
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        state <= S_IDLE;
                        req_q <= 1'b0;
                        if (!(killed || flush)) begin
                            wb_valid <= 1'b1;
                            wb_en    <= 1'b0;
                            wb_reg   <= lat_reg;
                            bus_err  <= 1'b1;
                            exc_addr <= lat_addr;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: each task drives one scenario and
// compares the DUT against hand-computed values.
module tb_mem_access_stage;
    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_wb_reg;
    logic        ex_wb_en;
    logic        flush;
    logic        mem_stall_req;
    logic        wb_valid;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        addr_exc;
    logic        bus_err;
    logic [31:0] exc_addr;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_access_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_mem_op     (ex_mem_op),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_wb_reg     (ex_wb_reg),
        .ex_wb_en      (ex_wb_en),
        .flush         (flush),
        .mem_stall_req (mem_stall_req),
        .ram           (bus),
        .wb_valid      (wb_valid),
        .wb_en         (wb_en),
        .wb_reg        (wb_reg),
        .wb_data       (wb_data),
        .addr_exc      (addr_exc),
        .bus_err       (bus_err),
        .exc_addr      (exc_addr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single cycle; returns just after the edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] res,
                         input logic [31:0] sdata, input logic [4:0] rd,
                         input logic en);
        ex_valid      = 1'b1;
        ex_mem_op     = op;
        ex_result     = res;
        ex_store_data = sdata;
        ex_wb_reg     = rd;
        ex_wb_en      = en;
        step();
        ex_valid      = 1'b0;
        ex_mem_op     = OP_NONE;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({wb_valid, wb_en, addr_exc, bus_err, mem_stall_req, bus.ram_req, bus.ram_we} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {wb_valid, wb_en, addr_exc, bus_err, mem_stall_req, bus.ram_req, bus.ram_we});
        end
        n_checks++;
        if ({wb_data, exc_addr, bus.ram_addr, bus.ram_wdata, bus.ram_be, wb_reg} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: wb_data=%h exc_addr=%h addr=%h wdata=%h be=%b reg=%0d expected all 0",
                     wb_data, exc_addr, bus.ram_addr, bus.ram_wdata, bus.ram_be, wb_reg);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_none_op();
        issue(OP_NONE, 32'h1234_5678, 32'h0, 5'd3, 1'b1);
        n_checks++;
        if ({wb_valid, wb_en, wb_reg, wb_data} !== {1'b1, 1'b1, 5'd3, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL none_wb: got v=%b en=%b reg=%0d data=%h expected v=1 en=1 reg=3 data=12345678",
                     wb_valid, wb_en, wb_reg, wb_data);
        end
        n_checks++;
        if ({bus.ram_req, mem_stall_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL none_bus: got req=%b stall=%b expected 0 0", bus.ram_req, mem_stall_req);
        end
        // Opcode 12 is reserved and behaves as NONE.
        issue(4'd12, 32'h0000_0AAA, 32'h0, 5'd9, 1'b0);
        step();
        n_checks++;
        if ({wb_valid, wb_en, wb_reg, wb_data, bus.ram_req} !== {1'b0, 1'b0, 5'd9, 32'h0000_0AAA, 1'b0}) begin
            n_fail++;
            $display("FAIL none_hold: got v=%b en=%b reg=%0d data=%h req=%b expected v=0 en=0 reg=9 data=00000aaa req=0",
                     wb_valid, wb_en, wb_reg, wb_data, bus.ram_req);
        end
    endtask

    task automatic test_loads();
        logic [3:0]  op;
        logic [31:0] addr, rd, exp_data, exp_addr;
        int          stall_cycles, unstable, early_wb;
        for (int v = 0; v < 5; v++) begin
            case (v)
                0: begin op = OP_LB;  addr = 32'h103; rd = 32'h80FF_0011; exp_data = 32'hFFFF_FF80; exp_addr = 32'h100; end
                1: begin op = OP_LBU; addr = 32'h103; rd = 32'h80FF_0011; exp_data = 32'h0000_0080; exp_addr = 32'h100; end
                2: begin op = OP_LH;  addr = 32'h102; rd = 32'h8001_7FFF; exp_data = 32'hFFFF_8001; exp_addr = 32'h100; end
                3: begin op = OP_LHU; addr = 32'h100; rd = 32'h1234_ABCD; exp_data = 32'h0000_ABCD; exp_addr = 32'h100; end
                default: begin op = OP_LW; addr = 32'h104; rd = 32'hDEAD_BEEF; exp_data = 32'hDEAD_BEEF; exp_addr = 32'h104; end
            endcase
            stall_cycles = 0;
            unstable     = 0;
            early_wb     = 0;
            issue(op, addr, 32'h5555_5555, 5'(5 + v), 1'b1);
            for (int i = 0; i < 4; i++) begin
                if (mem_stall_req) stall_cycles++;
                if (bus.ram_req !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== exp_addr ||
                    bus.ram_be !== 4'b1111) unstable++;
                if (wb_valid) early_wb++;
                if (i < 3) step();
            end
            bus.ram_ack   = 1'b1;
            bus.ram_rdata = rd;
            step();
            bus.ram_ack   = 1'b0;
            bus.ram_rdata = 32'h0;
            n_checks++;
            if (stall_cycles != 4 || unstable != 0 || early_wb != 0) begin
                n_fail++;
                $display("FAIL load%0d_bus: got stall=%0d unstable=%0d early_wb=%0d expected 4 0 0",
                         v, stall_cycles, unstable, early_wb);
            end
            n_checks++;
            if ({wb_valid, wb_en, wb_reg, wb_data, bus.ram_req, mem_stall_req} !==
                {1'b1, 1'b1, 5'(5 + v), exp_data, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL load%0d_wb: got v=%b en=%b reg=%0d data=%h req=%b stall=%b expected v=1 en=1 reg=%0d data=%h req=0 stall=0",
                         v, wb_valid, wb_en, wb_reg, wb_data, bus.ram_req, mem_stall_req, 5 + v, exp_data);
            end
        end
    endtask

    task automatic test_stores();
        logic [3:0]  op, exp_be;
        logic [31:0] addr, sd, exp_wd, exp_addr;
        for (int v = 0; v < 3; v++) begin
            case (v)
                0: begin op = OP_SH; addr = 32'h202; sd = 32'hABCD_1234; exp_be = 4'b1100; exp_wd = 32'h1234_1234; exp_addr = 32'h200; end
                1: begin op = OP_SB; addr = 32'h101; sd = 32'h0000_00EE; exp_be = 4'b0010; exp_wd = 32'hEEEE_EEEE; exp_addr = 32'h100; end
                default: begin op = OP_SW; addr = 32'h20C; sd = 32'hCAFE_F00D; exp_be = 4'b1111; exp_wd = 32'hCAFE_F00D; exp_addr = 32'h20C; end
            endcase
            issue(op, addr, sd, 5'd7, 1'b1);
            n_checks++;
            if ({bus.ram_req, bus.ram_we, bus.ram_be, bus.ram_wdata, bus.ram_addr} !==
                {1'b1, 1'b1, exp_be, exp_wd, exp_addr}) begin
                n_fail++;
                $display("FAIL store%0d_bus: got req=%b we=%b be=%b wdata=%h addr=%h expected 1 1 %b %h %h",
                         v, bus.ram_req, bus.ram_we, bus.ram_be, bus.ram_wdata, bus.ram_addr,
                         exp_be, exp_wd, exp_addr);
            end
            bus.ram_ack = 1'b1;
            step();
            bus.ram_ack = 1'b0;
            n_checks++;
            if ({wb_valid, wb_en, bus.ram_req, mem_stall_req} !== 4'b1000) begin
                n_fail++;
                $display("FAIL store%0d_wb: got v=%b en=%b req=%b stall=%b expected 1 0 0 0",
                         v, wb_valid, wb_en, bus.ram_req, mem_stall_req);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [3:0]  op;
        logic [31:0] addr;
        for (int v = 0; v < 3; v++) begin
            case (v)
                0: begin op = OP_LW; addr = 32'h206; end
                1: begin op = OP_LH; addr = 32'h101; end
                default: begin op = OP_SW; addr = 32'h303; end
            endcase
            issue(op, addr, 32'h1111_1111, 5'd4, 1'b1);
            n_checks++;
            if ({addr_exc, exc_addr, wb_valid, wb_en, bus.ram_req, mem_stall_req} !==
                {1'b1, addr, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL misalign%0d: got exc=%b addr=%h v=%b en=%b req=%b stall=%b expected 1 %h 1 0 0 0",
                         v, addr_exc, exc_addr, wb_valid, wb_en, bus.ram_req, mem_stall_req, addr);
            end
            step();
            n_checks++;
            if ({addr_exc, wb_valid, bus.ram_req} !== 3'b000) begin
                n_fail++;
                $display("FAIL misalign%0d_pulse: got exc=%b v=%b req=%b expected 0 0 0",
                         v, addr_exc, wb_valid, bus.ram_req);
            end
        end
    endtask

    task automatic test_timeout();
        int req_cycles, early;
        req_cycles = 0;
        issue(OP_SW, 32'h300, 32'h0BAD_F00D, 5'd2, 1'b1);
        while (bus.ram_req === 1'b1 && req_cycles < 40) begin
            req_cycles++;
            step();
        end
        n_checks++;
        if (req_cycles != 16) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d req cycles expected 16", req_cycles);
        end
        n_checks++;
        if ({bus_err, exc_addr, wb_valid, wb_en, mem_stall_req} !== {1'b1, 32'h300, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_err: got err=%b addr=%h v=%b en=%b stall=%b expected 1 00000300 1 0 0",
                     bus_err, exc_addr, wb_valid, wb_en, mem_stall_req);
        end
        issue(OP_NONE, 32'h0000_00C3, 32'h0, 5'd6, 1'b1);
        n_checks++;
        if ({bus_err, wb_valid, wb_en, wb_data} !== {1'b0, 1'b1, 1'b1, 32'h0000_00C3}) begin
            n_fail++;
            $display("FAIL timeout_after: got err=%b v=%b en=%b data=%h expected 0 1 1 000000c3",
                     bus_err, wb_valid, wb_en, wb_data);
        end
        // Ack on the final allowed cycle beats the timeout; EX traffic is ignored meanwhile.
        early = 0;
        issue(OP_LW, 32'h400, 32'h0, 5'd8, 1'b1);
        ex_valid  = 1'b1;
        ex_mem_op = OP_NONE;
        ex_result = 32'h7777_7777;
        for (int i = 0; i < 15; i++) begin
            step();
            if (wb_valid || bus_err || bus.ram_req !== 1'b1) early++;
        end
        ex_valid      = 1'b0;
        bus.ram_ack   = 1'b1;
        bus.ram_rdata = 32'h0102_0304;
        step();
        bus.ram_ack   = 1'b0;
        n_checks++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL ack_last_wait: got %0d bad cycles expected 0", early);
        end
        n_checks++;
        if ({bus_err, wb_valid, wb_en, wb_data, bus.ram_req} !== {1'b0, 1'b1, 1'b1, 32'h0102_0304, 1'b0}) begin
            n_fail++;
            $display("FAIL ack_last_wb: got err=%b v=%b en=%b data=%h req=%b expected 0 1 1 01020304 0",
                     bus_err, wb_valid, wb_en, wb_data, bus.ram_req);
        end
    endtask

    task automatic test_flush();
        int stall_cycles, wb_seen;
        stall_cycles = 0;
        wb_seen      = 0;
        issue(OP_LW, 32'h500, 32'h0, 5'd10, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            if (mem_stall_req) stall_cycles++;
            if (wb_valid) wb_seen++;
            flush = (i == 2);
            if (i == 5) begin
                bus.ram_ack   = 1'b1;
                bus.ram_rdata = 32'hFEED_FACE;
            end
            step();
        end
        flush       = 1'b0;
        bus.ram_ack = 1'b0;
        n_checks++;
        if (stall_cycles != 5 || wb_seen != 0) begin
            n_fail++;
            $display("FAIL flush_bus: got stall=%0d wb=%0d expected 5 0", stall_cycles, wb_seen);
        end
        n_checks++;
        if ({wb_valid, bus_err, addr_exc, bus.ram_req, mem_stall_req} !== 5'b0) begin
            n_fail++;
            $display("FAIL flush_done: got v=%b err=%b exc=%b req=%b stall=%b expected 0 0 0 0 0",
                     wb_valid, bus_err, addr_exc, bus.ram_req, mem_stall_req);
        end
        flush = 1'b1;
        issue(OP_NONE, 32'h0000_0042, 32'h0, 5'd1, 1'b1);
        flush = 1'b0;
        n_checks++;
        if ({wb_valid, bus.ram_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_idle: got v=%b req=%b expected 0 0", wb_valid, bus.ram_req);
        end
    endtask

    task automatic test_reset_in_bus();
        issue(OP_SW, 32'h600, 32'h1357_9BDF, 5'd11, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({bus.ram_req, mem_stall_req, wb_valid, bus_err, bus.ram_be, bus.ram_wdata, wb_data} !== '0) begin
            n_fail++;
            $display("FAIL rst_bus: got req=%b stall=%b v=%b err=%b be=%b wdata=%h data=%h expected all 0",
                     bus.ram_req, mem_stall_req, wb_valid, bus_err, bus.ram_be, bus.ram_wdata, wb_data);
        end
        step();
        issue(OP_NONE, 32'h0000_BEEF, 32'h0, 5'd12, 1'b1);
        n_checks++;
        if ({wb_valid, wb_reg, wb_data} !== {1'b1, 5'd12, 32'h0000_BEEF}) begin
            n_fail++;
            $display("FAIL rst_bus_after: got v=%b reg=%0d data=%h expected 1 12 0000beef",
                     wb_valid, wb_reg, wb_data);
        end
    endtask

    initial begin
        rst           = 1'b1;
        ex_valid      = 1'b0;
        ex_mem_op     = OP_NONE;
        ex_result     = '0;
        ex_store_data = '0;
        ex_wb_reg     = '0;
        ex_wb_en      = 1'b0;
        flush         = 1'b0;
        bus.ram_ack   = 1'b0;
        bus.ram_rdata = '0;
        test_reset();
        test_none_op();
        test_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_flush();
        test_reset_in_bus();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
